vscale_gpu_irq_ctrl: RTL and testbench
======================================

# vscale_gpu_irq_ctrl

Memory-mapped completion and interrupt controller for the SYMPL GP-GPU. It sits downstream of the dual-port HASTI SRAM/GPU block and consumes the GPU `DONE` strobe. It exposes a small HASTI slave register window to the V-scale data port, and drives one level interrupt line into the core. It counts GPU completions, latches a pending flag, and runs a watchdog that flags a GPU job that never completes.

## Interface
Parameters:
- `CNT_W`, 16: width of the completion counter.
- `BASE_SEL`, 14'h0002: value of `haddr[31:18]` that selects this window.

Ports:
- `hclk` in 1: single clock for the bus, the registers and the GPU `DONE` domain.
- `RESET` in 1: asynchronous, active-high reset (driven from `~hresetn`).
- `haddr` in 32: HASTI address.
- `hwrite` in 1: HASTI write.
- `hsize` in 3: HASTI size. Ignored; all accesses are full-word.
- `htrans` in 2: HASTI transfer type. Only NONSEQ is acted on.
- `hwdata` in 32: HASTI write data, valid in the data phase.
- `hrdata` out 32: HASTI read data.
- `hready` out 1: constant 1.
- `hresp` out 1: constant OKAY.
- `gpu_done` in 1: GPU `DONE` level, synchronous to `hclk`.
- `irq` out 1: interrupt request to the core, level, active-high.

## Operation
- Access decode: an access is selected when `htrans`==NONSEQ and `haddr[31:18]`==`BASE_SEL`. Register offset is `haddr[4:2]`.
- Register map. Unmapped offsets read 0 and ignore writes.
  - 0x00 CTRL: bit0 `irq_en`, bit1 `wd_en`. R/W.
  - 0x04 STATUS:
    - bit0 `pending`: W1C.
    - bit1 `timeout`: W1C.
    - bit2 `overflow`: W1C.
    - bit3 `gpu_done` live level: RO.
    - bits5:4 watchdog state: RO.
  - 0x08 DONE_COUNT: `CNT_W`-bit completion count, zero-extended. Any write clears it to 0.
  - 0x0C WD_RELOAD: 32-bit watchdog reload value. R/W.
  - 0x10 WD_START: write-only trigger (reads 0). A write arms the watchdog.
  - 0x14 WD_COUNT: current watchdog countdown. RO.
- Completion edge: `done_q` is a registered copy of `gpu_done`. A completion edge is `gpu_done & ~done_q`. On each edge:
  - Set `pending`.
  - Increment DONE_COUNT. At the all-ones value it saturates and sets `overflow` instead of wrapping.
  - Disarm the watchdog if it is ARMED.
- Watchdog FSM:
  - IDLE (00): a WD_START write with `wd_en`=1 and WD_RELOAD≠0 loads WD_COUNT=WD_RELOAD and goes to ARMED. If WD_RELOAD==0 or `wd_en`=0, the write is ignored.
  - ARMED (01): WD_COUNT decrements by 1 each cycle.
    - A completion edge returns to IDLE.
    - WD_COUNT reaching 0 sets `timeout` and goes to EXPIRED.
    - Clearing `wd_en` returns to IDLE.
    - A new WD_START reloads the count and stays ARMED.
  - EXPIRED (10): holds until `timeout` is W1C'd, then goes to IDLE. A completion edge here counts normally but does not clear `timeout`.
- `irq` = `irq_en & (pending | timeout | overflow)`, registered.

## Timing
- Reset values: all registers 0, `done_q`=1 (no spurious edge if `gpu_done` is high at release), FSM IDLE, `irq`=0, `hrdata`=0.
- Address phase: `haddr`/`hwrite`/selection are registered at the end of the address phase.
- Writes: `hwdata` is sampled in the following (data) cycle. The register updates at the end of the data phase. Back-to-back NONSEQ writes are supported with zero wait states.
- Reads: `hrdata` is a combinational mux of the register selected by the registered address. It is valid in the data phase, one cycle after the address phase. It reflects register state before any same-cycle update.
- Read-after-write to the same offset in the next access returns the new value (write committed before the read's data phase ends).
- Simultaneous events: set beats clear. A completion edge in the same cycle as a W1C of `pending` leaves `pending`=1. The same rule applies to the `timeout` set at count 0 against its W1C.
- A DONE_COUNT clear write coinciding with an edge yields DONE_COUNT=1.
- `irq` latency: asserts 2 cycles after the `gpu_done` rising edge. It deasserts 1 cycle after the commit of the W1C or `irq_en` clear.
- `RESET` asserted mid-access or mid-countdown returns everything to reset values immediately (asynchronous). No partial write survives.

## Structure
- Shared package `vscale_gpu_irq_pkg`:
  - Register offset constants.
  - Watchdog state encodings (IDLE=2'b00, ARMED=2'b01, EXPIRED=2'b10).
  - STATUS bit positions.
- HASTI width/trans constants come from the existing HASTI constants header.
- One natural sub-module: `gpu_watchdog`, containing the FSM and countdown. It takes start, reload, enable, done_edge and clear_timeout, and outputs state, count and timeout_set.

## Test plan
- Reset: hold `gpu_done`=1 through reset release. Expect STATUS=0x8, DONE_COUNT=0, `irq`=0. No edge is counted.
- Completion interrupt:
  - Write CTRL=1.
  - Pulse `gpu_done` 0→1. `irq`=1 two cycles later; DONE_COUNT reads 1.
  - Write STATUS=0x1. `irq` drops one cycle after commit.
- Set-beats-clear: drive a `gpu_done` rising edge in the same cycle as the W1C data phase of `pending`. STATUS bit0 reads 1 afterwards.
- Watchdog expiry:
  - Write CTRL=3, WD_RELOAD=5, then WD_START.
  - Without `gpu_done`, `timeout` sets at 5 cycles after the commit and the state reads EXPIRED.
  - W1C of `timeout` returns the state to IDLE.
- Watchdog disarm and zero reload:
  - Arm with reload 100 and pulse `gpu_done` at cycle 10. State reads IDLE with no timeout.
  - WD_START with WD_RELOAD=0 leaves the state IDLE.
- Saturation: force 2^`CNT_W` edges (use `CNT_W`=4 in the bench). DONE_COUNT stays at 0xF, `overflow`=1, `irq`=1 with `irq_en` set.

Source files
------------

// File: rtl/vscale_gpu_irq_pkg.sv
// vscale_gpu_irq_pkg: shared constants for the GPU completion/interrupt controller
package vscale_gpu_irq_pkg;
  localparam int HASTI_BUS_WIDTH = 32;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic HRESP_OKAY = 1'b0;
  localparam logic [2:0] OFF_CTRL = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_COUNT = 3'd2;
  localparam logic [2:0] OFF_RELOAD = 3'd3;
  localparam logic [2:0] OFF_START = 3'd4;
  localparam logic [2:0] OFF_WDCNT = 3'd5;
  localparam int ST_PEND = 0;
  localparam int ST_TIMEOUT = 1;
  localparam int ST_OVF = 2;
  typedef enum logic [1:0] {
    WD_IDLE = 2'b00,
    WD_ARMED = 2'b01,
    WD_EXPIRED = 2'b10
  } wd_state_t;
endpackage

// File: rtl/gpu_watchdog.sv
// gpu_watchdog: countdown that flags a GPU job which never signals completion
module gpu_watchdog
  import vscale_gpu_irq_pkg::*;
(
  input  logic        hclk,
  input  logic        RESET,
  input  logic        start,
  input  logic [31:0] reload,
  input  logic        en,
  input  logic        done_edge,
  input  logic        clear_timeout,
  output wd_state_t   state,
  output logic [31:0] count,
  output logic        timeout_set
);
  wd_state_t state_n;
  logic [31:0] count_n;
  logic go;
  assign go = start & en & (reload != '0);
  // state and countdown registers
  always_ff @(posedge hclk or posedge RESET)
    if (RESET) begin
      state <= WD_IDLE;
      count <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
    end
  // next state: done or disable disarms, restart reloads, count hitting 0 expires
  always_comb begin
    state_n = state;
    count_n = count;
    timeout_set = 1'b0;
    case (state)
      WD_IDLE: if (go) begin
        state_n = WD_ARMED;
        count_n = reload;
      end
      WD_ARMED: if (!en || done_edge) state_n = WD_IDLE;
      else if (go) count_n = reload;
      else begin
        count_n = count - 32'd1;
        if (count == 32'd1) begin
          state_n = WD_EXPIRED;
          timeout_set = 1'b1;
        end
      end
      WD_EXPIRED: if (clear_timeout) state_n = WD_IDLE;
      default: state_n = WD_IDLE;
    endcase
  end
endmodule

// File: rtl/vscale_gpu_irq_ctrl.sv
// vscale_gpu_irq_ctrl: HASTI register window counting GPU completions and raising irq
module vscale_gpu_irq_ctrl
  import vscale_gpu_irq_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter logic [13:0] BASE_SEL = 14'h0002
) (
  input  logic        hclk,
  input  logic        RESET,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [1:0]  htrans,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp,
  input  logic        gpu_done,
  output logic        irq
);
  logic sel_q, wr_q, done_q, pending, timeout, overflow, done_edge, to_set, cnt_max;
  logic w_ctrl, w_status, w_count, w_reload, w_start;
  logic [2:0] off_q;
  logic [1:0] ctrl;
  logic [CNT_W-1:0] cnt;
  logic [31:0] reload, wd_count;
  wd_state_t wd_state;
  logic unused_addr;
  assign unused_addr = ^{hsize, haddr[17:5], haddr[1:0]};
  assign hready = 1'b1;
  assign hresp = HRESP_OKAY;
  assign done_edge = gpu_done & ~done_q;
  assign cnt_max = &cnt;
  assign w_ctrl = sel_q & wr_q & (off_q == OFF_CTRL);
  assign w_status = sel_q & wr_q & (off_q == OFF_STATUS);
  assign w_count = sel_q & wr_q & (off_q == OFF_COUNT);
  assign w_reload = sel_q & wr_q & (off_q == OFF_RELOAD);
  assign w_start = sel_q & wr_q & (off_q == OFF_START);
  // address phase capture; data phase follows with zero wait states
  always_ff @(posedge hclk or posedge RESET)
    if (RESET) begin
      sel_q <= 1'b0;
      wr_q <= 1'b0;
      off_q <= '0;
    end else begin
      sel_q <= (htrans == HTRANS_NONSEQ) && (haddr[31:18] == BASE_SEL);
      wr_q <= hwrite;
      off_q <= haddr[4:2];
    end
  // register file and sticky status; in every W1C race the set wins
  always_ff @(posedge hclk or posedge RESET)
    if (RESET) begin
      done_q <= 1'b1;
      ctrl <= '0;
      reload <= '0;
      pending <= 1'b0;
      timeout <= 1'b0;
      overflow <= 1'b0;
      cnt <= '0;
      irq <= 1'b0;
    end else begin
      done_q <= gpu_done;
      if (w_ctrl) ctrl <= hwdata[1:0];
      if (w_reload) reload <= hwdata;
      pending <= done_edge | (pending & ~(w_status & hwdata[ST_PEND]));
      timeout <= to_set | (timeout & ~(w_status & hwdata[ST_TIMEOUT]));
      overflow <= (done_edge & cnt_max) | (overflow & ~(w_status & hwdata[ST_OVF]));
      cnt <= w_count ? CNT_W'(done_edge) : cnt + CNT_W'(done_edge & ~cnt_max);
      irq <= ctrl[0] & (pending | timeout | overflow);
    end
  gpu_watchdog u_wd (
    .hclk(hclk),
    .RESET(RESET),
    .start(w_start),
    .reload(reload),
    .en(ctrl[1]),
    .done_edge(done_edge),
    .clear_timeout(w_status & hwdata[ST_TIMEOUT]),
    .state(wd_state),
    .count(wd_count),
    .timeout_set(to_set)
  );
  assign hrdata = !sel_q ? '0 :
                  off_q == OFF_CTRL ? {30'b0, ctrl} :
                  off_q == OFF_STATUS ? {26'b0, wd_state, gpu_done, overflow, timeout, pending} :
                  off_q == OFF_COUNT ? 32'(cnt) :
                  off_q == OFF_RELOAD ? reload :
                  off_q == OFF_WDCNT ? wd_count : '0;
endmodule

// File: tb/tb_vscale_gpu_irq_ctrl.sv
// tb_vscale_gpu_irq_ctrl: directed self-checking bench for the GPU irq controller
module tb_vscale_gpu_irq_ctrl;
  localparam logic [31:0] B = 32'h0008_0000;
  logic hclk = 1'b0, RESET = 1'b1, hwrite = 1'b0, gpu_done = 1'b1;
  logic [31:0] haddr = '0, hwdata = '0, hrdata, rv;
  logic [2:0] hsize = 3'b010;
  logic [1:0] htrans = 2'b00;
  logic hready, hresp, irq;
  int n_chk = 0, n_fail = 0;

  vscale_gpu_irq_ctrl #(.CNT_W(4), .BASE_SEL(14'h0002)) dut (
    .hclk(hclk), .RESET(RESET), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
    .htrans(htrans), .hwdata(hwdata), .hrdata(hrdata), .hready(hready),
    .hresp(hresp), .gpu_done(gpu_done), .irq(irq)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic pulse);
    @(posedge hclk); #1;
    haddr = a; hwrite = 1'b1; htrans = 2'b10;
    @(posedge hclk); #1;
    htrans = 2'b00; hwrite = 1'b0; hwdata = d;
    if (pulse) gpu_done = 1'b1;
    @(posedge hclk); #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(posedge hclk); #1;
    haddr = a; hwrite = 1'b0; htrans = 2'b10;
    @(posedge hclk); #1;
    htrans = 2'b00;
    d = hrdata;
  endtask

  task automatic pulse_done();
    @(posedge hclk); #1 gpu_done = 1'b1;
    @(posedge hclk); #1 gpu_done = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge hclk);
    #1 RESET = 1'b0;
    check("hready", {31'b0, hready}, 32'd1);
    check("hresp", {31'b0, hresp}, 32'd0);
    check("reset_irq", {31'b0, irq}, 32'd0);
    rd(B + 32'h04, rv); check("reset_status", rv, 32'h8);
    rd(B + 32'h08, rv); check("reset_count", rv, 32'h0);
    gpu_done = 1'b0;
    wr(B + 32'h00, 32'h1, 1'b0);
    rd(B + 32'h00, rv); check("ctrl_raw", rv, 32'h1);
    wr(32'h000C_0000, 32'h3, 1'b0);
    rd(B + 32'h00, rv); check("wrong_base_ignored", rv, 32'h1);
    @(posedge hclk); #1 gpu_done = 1'b1;
    @(posedge hclk); #1 check("irq_lat1", {31'b0, irq}, 32'd0);
    gpu_done = 1'b0;
    @(posedge hclk); #1 check("irq_lat2", {31'b0, irq}, 32'd1);
    rd(B + 32'h08, rv); check("count_one", rv, 32'h1);
    wr(B + 32'h04, 32'h1, 1'b0);
    check("irq_at_commit", {31'b0, irq}, 32'd1);
    @(posedge hclk); #1 check("irq_drop", {31'b0, irq}, 32'd0);
    wr(B + 32'h04, 32'h1, 1'b1);
    gpu_done = 1'b0;
    rd(B + 32'h04, rv); check("set_beats_clear", rv, 32'h1);
    rd(B + 32'h08, rv); check("count_two", rv, 32'h2);
    wr(B + 32'h08, 32'h0, 1'b1);
    gpu_done = 1'b0;
    rd(B + 32'h08, rv); check("clear_with_edge", rv, 32'h1);
    wr(B + 32'h04, 32'h7, 1'b0);
    wr(B + 32'h00, 32'h3, 1'b0);
    wr(B + 32'h0C, 32'd5, 1'b0);
    rd(B + 32'h0C, rv); check("reload_raw", rv, 32'd5);
    check("irq_before_wd", {31'b0, irq}, 32'd0);
    wr(B + 32'h10, 32'h0, 1'b0);
    rd(B + 32'h14, rv); check("wd_count_c2", rv, 32'd3);
    rd(B + 32'h04, rv); check("wd_armed_c4", rv, 32'h10);
    rd(B + 32'h04, rv); check("wd_expired_c6", rv, 32'h22);
    check("irq_timeout", {31'b0, irq}, 32'd1);
    rd(B + 32'h14, rv); check("wd_count_zero", rv, 32'd0);
    rd(B + 32'h10, rv); check("start_reads0", rv, 32'd0);
    wr(B + 32'h04, 32'h2, 1'b0);
    rd(B + 32'h04, rv); check("timeout_cleared", rv, 32'h0);
    check("irq_timeout_drop", {31'b0, irq}, 32'd0);
    wr(B + 32'h0C, 32'd100, 1'b0);
    wr(B + 32'h10, 32'h0, 1'b0);
    repeat (10) @(posedge hclk);
    #1 gpu_done = 1'b1;
    @(posedge hclk); #1 gpu_done = 1'b0;
    rd(B + 32'h04, rv); check("disarm_idle", rv, 32'h1);
    repeat (120) @(posedge hclk);
    rd(B + 32'h04, rv); check("disarm_no_timeout", rv, 32'h1);
    wr(B + 32'h04, 32'h1, 1'b0);
    wr(B + 32'h0C, 32'd0, 1'b0);
    wr(B + 32'h10, 32'h0, 1'b0);
    rd(B + 32'h04, rv); check("zero_reload_idle", rv, 32'h0);
    wr(B + 32'h00, 32'h1, 1'b0);
    wr(B + 32'h0C, 32'd5, 1'b0);
    wr(B + 32'h10, 32'h0, 1'b0);
    rd(B + 32'h04, rv); check("wd_disabled_idle", rv, 32'h0);
    wr(B + 32'h18, 32'hFFFF_FFFF, 1'b0);
    rd(B + 32'h18, rv); check("unmapped_reads0", rv, 32'h0);
    wr(B + 32'h08, 32'h0, 1'b0);
    repeat (15) pulse_done();
    rd(B + 32'h08, rv); check("count_15", rv, 32'hF);
    rd(B + 32'h04, rv); check("no_ovf_yet", rv, 32'h1);
    pulse_done();
    rd(B + 32'h08, rv); check("count_sat", rv, 32'hF);
    rd(B + 32'h04, rv); check("ovf_set", rv, 32'h5);
    check("irq_ovf", {31'b0, irq}, 32'd1);
    wr(B + 32'h04, 32'h7, 1'b0);
    wr(B + 32'h00, 32'h3, 1'b0);
    wr(B + 32'h0C, 32'd50, 1'b0);
    wr(B + 32'h10, 32'h0, 1'b0);
    pulse_done();
    wr(B + 32'h10, 32'h0, 1'b0);
    repeat (2) @(posedge hclk);
    #1 check("irq_pre_reset", {31'b0, irq}, 32'd1);
    #3 RESET = 1'b1;
    #1 check("irq_async_reset", {31'b0, irq}, 32'd0);
    @(posedge hclk); #1 RESET = 1'b0;
    rd(B + 32'h04, rv); check("post_reset_status", rv, 32'h0);
    rd(B + 32'h00, rv); check("post_reset_ctrl", rv, 32'h0);
    rd(B + 32'h0C, rv); check("post_reset_reload", rv, 32'h0);
    rd(B + 32'h14, rv); check("post_reset_wdcount", rv, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
